// File: rtl/cordic_rot_iter.sv
// Iterative CORDIC rotation engine: replays N_ITER stored direction bits on (x, y), one micro-rotation per clock.
// Optional gain compensation stage enabled by defining CORDIC_ROT_SCALE_COMP_EN.
module cordic_rot_iter #(
   parameter int CORDIC_WIDTH = 22,
   parameter int N_ITER       = 16
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           enable,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic signed [CORDIC_WIDTH-1:0] x_in,
   input  logic signed [CORDIC_WIDTH-1:0] y_in,
   input  logic        [N_ITER-1:0]       dir_in,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic signed [CORDIC_WIDTH-1:0] x_out,
   output logic signed [CORDIC_WIDTH-1:0] y_out,
   output logic                           rot_active
);

   localparam int K_W = (N_ITER > 1) ? $clog2(N_ITER) : 1;
   localparam logic [K_W-1:0] K_LAST = K_W'(N_ITER - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ROT  = 2'd1,
`ifdef CORDIC_ROT_SCALE_COMP_EN
      SCALE = 2'd3,
`endif
      DONE = 2'd2
   } state_t;

   state_t                    state, state_nxt;
   logic [K_W-1:0]            k;
   logic signed [CORDIC_WIDTH-1:0] x_r, y_r;
   logic        [N_ITER-1:0]       dir_r;
   logic signed [CORDIC_WIDTH-1:0] x_sh, y_sh, x_rot, y_rot;
   logic                           accept;

   assign in_ready = (state == IDLE) && enable && !reset;
   assign accept   = in_valid && in_ready;

`ifdef CORDIC_ROT_SCALE_COMP_EN
   // Approximates 1/1.6468 with four shifted terms; two guard bits keep the partial sums exact.
   function automatic logic signed [CORDIC_WIDTH-1:0] scale_gain(input logic signed [CORDIC_WIDTH-1:0] v);
      logic signed [CORDIC_WIDTH+1:0] e, s;
      e = {{2{v[CORDIC_WIDTH-1]}}, v};
      s = (e >>> 1) + (e >>> 3) - (e >>> 6) - (e >>> 9);
      return s[CORDIC_WIDTH-1:0];
   endfunction
`endif

   // Both updates read the old x/y; the sums wrap at CORDIC_WIDTH by design.
   always_comb begin
      x_sh  = x_r >>> k;
      y_sh  = y_r >>> k;
      x_rot = dir_r[k] ? (x_r - y_sh) : (x_r + y_sh);
      y_rot = dir_r[k] ? (y_r + x_sh) : (y_r - x_sh);
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
   always_comb begin
      state_nxt = state;
      if (!enable) begin
         state_nxt = IDLE;
      end else begin
         unique case (state)
            IDLE: if (accept) state_nxt = ROT;
            ROT: begin
               if (k == K_LAST) begin
`ifdef CORDIC_ROT_SCALE_COMP_EN
                  state_nxt = SCALE;
`else
                  state_nxt = DONE;
`endif
               end
            end
`ifdef CORDIC_ROT_SCALE_COMP_EN
            SCALE: state_nxt = DONE;
`endif
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   // NOTE: working registers are left out of reset; they are always loaded on acceptance before use.
   always_ff @(posedge clk) begin
      if (accept) begin
         x_r   <= x_in;
         y_r   <= y_in;
         dir_r <= dir_in;
      end else if (state == ROT) begin
         x_r <= x_rot;
         y_r <= y_rot;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset || !enable) begin
         k          <= '0;
         x_out      <= '0;
         y_out      <= '0;
         out_valid  <= 1'b0;
         rot_active <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (accept) begin
                  k          <= '0;
                  rot_active <= 1'b1;
               end
            end
            ROT: begin
               k <= k + 1'b1;
`ifndef CORDIC_ROT_SCALE_COMP_EN
               if (k == K_LAST) begin
                  x_out      <= x_rot;
                  y_out      <= y_rot;
                  out_valid  <= 1'b1;
                  rot_active <= 1'b0;
               end
`endif
            end
`ifdef CORDIC_ROT_SCALE_COMP_EN
            SCALE: begin
               x_out      <= scale_gain(x_r);
               y_out      <= scale_gain(y_r);
               out_valid  <= 1'b1;
               rot_active <= 1'b0;
            end
`endif
            DONE: if (out_ready) out_valid <= 1'b0;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cordic_rot_iter.sv
// Self-checking bench for cordic_rot_iter: two instances (N_ITER=2 and 16) checked against a plain-arithmetic model.
module tb_cordic_rot_iter;

   localparam int W = 22;
`ifdef CORDIC_ROT_SCALE_COMP_EN
   localparam int EXTRA = 1;
   localparam bit DO_SCALE = 1'b1;
`else
   localparam int EXTRA = 0;
   localparam bit DO_SCALE = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset, enable;
   logic in_valid[2], in_ready[2], out_valid[2], out_ready[2], rot_active[2];
   logic signed [W-1:0] x_in[2], y_in[2], x_out[2], y_out[2];
   logic [15:0] dir[2];
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   cordic_rot_iter #(.CORDIC_WIDTH(W), .N_ITER(2)) u_n2 (
      .clk(clk), .reset(reset), .enable(enable),
      .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .x_in(x_in[0]), .y_in(y_in[0]), .dir_in(dir[0][1:0]),
      .out_valid(out_valid[0]), .out_ready(out_ready[0]),
      .x_out(x_out[0]), .y_out(y_out[0]), .rot_active(rot_active[0])
   );

   cordic_rot_iter #(.CORDIC_WIDTH(W), .N_ITER(16)) u_n16 (
      .clk(clk), .reset(reset), .enable(enable),
      .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .x_in(x_in[1]), .y_in(y_in[1]), .dir_in(dir[1]),
      .out_valid(out_valid[1]), .out_ready(out_ready[1]),
      .x_out(x_out[1]), .y_out(y_out[1]), .rot_active(rot_active[1])
   );

   function automatic int n_of(input int u);
      return (u == 0) ? 2 : 16;
   endfunction

   function automatic longint wrapw(input longint v);
      logic signed [W-1:0] t;
      t = v[W-1:0];
      return longint'(t);
   endfunction

   // Reference: x' = x + s*(y>>i), y' = y - s*(x>>i), with s = -1 when the direction bit is set.
   function automatic void model(input int n, input longint x0, input longint y0, input logic [15:0] d,
                                 output longint xo, output longint yo);
      longint x, y, nx, ny, sg;
      x = x0;
      y = y0;
      for (int i = 0; i < n; i++) begin
         sg = d[i] ? -1 : 1;
         nx = wrapw(x + sg * (y >>> i));
         ny = wrapw(y - sg * (x >>> i));
         x = nx;
         y = ny;
      end
      if (DO_SCALE) begin
         x = wrapw((x >>> 1) + (x >>> 3) - (x >>> 6) - (x >>> 9));
         y = wrapw((y >>> 1) + (y >>> 3) - (y >>> 6) - (y >>> 9));
      end
      xo = x;
      yo = y;
   endfunction

   task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Starts at a negedge with the instance idle; ends at a negedge after the output handshake.
   task automatic run_op(input int u, input longint x, input longint y, input logic [15:0] d, input int hold);
      longint ex, ey;
      int edges;
      bit act_ok, stable;
      logic signed [W-1:0] r;
      model(n_of(u), x, y, d, ex, ey);
      check($sformatf("u%0d ready_before", u), in_ready[u], 1);
      x_in[u] = x[W-1:0];
      y_in[u] = y[W-1:0];
      dir[u] = d;
      in_valid[u] = 1'b1;
      @(posedge clk);
      #1;
      in_valid[u] = 1'b0;
      r = W'($urandom); x_in[u] = r;
      r = W'($urandom); y_in[u] = r;
      dir[u] = 16'($urandom);
      @(negedge clk);
      check($sformatf("u%0d ready_busy", u), in_ready[u], 0);
      edges = 0;
      act_ok = 1'b1;
      while (!out_valid[u] && edges < 200) begin
         if (!rot_active[u]) act_ok = 1'b0;
         @(posedge clk);
         edges++;
         @(negedge clk);
      end
      check($sformatf("u%0d latency", u), edges, n_of(u) + EXTRA);
      check($sformatf("u%0d rot_active_busy", u), act_ok, 1);
      check($sformatf("u%0d rot_active_done", u), rot_active[u], 0);
      check($sformatf("u%0d x_out", u), x_out[u], ex);
      check($sformatf("u%0d y_out", u), y_out[u], ey);
      if (hold > 0) begin
         stable = 1'b1;
         for (int h = 0; h < hold; h++) begin
            in_valid[u] = 1'b1;
            r = W'($urandom); x_in[u] = r;
            @(negedge clk);
            if (!out_valid[u] || x_out[u] !== ex[W-1:0] || y_out[u] !== ey[W-1:0] || in_ready[u] !== 1'b0)
               stable = 1'b0;
         end
         in_valid[u] = 1'b0;
         check($sformatf("u%0d hold_stable", u), stable, 1);
      end
      out_ready[u] = 1'b1;
      @(negedge clk);
      out_ready[u] = 1'b0;
      check($sformatf("u%0d valid_after_hs", u), out_valid[u], 0);
      check($sformatf("u%0d ready_after_hs", u), in_ready[u], 1);
   endtask

   initial begin
      logic signed [W-1:0] rx, ry;
      reset = 1'b1;
      enable = 1'b1;
      for (int u = 0; u < 2; u++) begin
         in_valid[u] = 1'b0; out_ready[u] = 1'b0;
         x_in[u] = '0; y_in[u] = '0; dir[u] = '0;
      end
      repeat (3) @(negedge clk);
      for (int u = 0; u < 2; u++) begin
         check($sformatf("u%0d rst_x", u), x_out[u], 0);
         check($sformatf("u%0d rst_y", u), y_out[u], 0);
         check($sformatf("u%0d rst_valid", u), out_valid[u], 0);
         check($sformatf("u%0d rst_active", u), rot_active[u], 0);
         check($sformatf("u%0d rst_ready", u), in_ready[u], 0);
      end
      reset = 1'b0;
      @(negedge clk);

      run_op(0, 1000, 0, 16'b00, 0);
      run_op(0, 1000, 0, 16'b11, 5);
      run_op(0, 2000000, 2000000, 16'b00, 0);
      run_op(1, 2000000, -2000000, 16'h0000, 0);
      run_op(1, -2097152, 2097151, 16'hffff, 2);
      for (int i = 0; i < 24; i++) begin
         rx = W'($urandom);
         ry = W'($urandom);
         run_op(i % 2, rx, ry, 16'($urandom), int'($urandom_range(0, 2)));
      end

      // Abort with enable low during ROT on the short instance.
      run_op(0, 1000, 0, 16'b00, 0);
      x_in[0] = 22'sd777; y_in[0] = 22'sd123; dir[0] = 16'h1; in_valid[0] = 1'b1;
      @(posedge clk);
      #1 in_valid[0] = 1'b0;
      @(negedge clk);
      check("abort_en rot_active_pre", rot_active[0], 1);
      enable = 1'b0;
      in_valid[0] = 1'b1;
      @(negedge clk);
      check("abort_en valid", out_valid[0], 0);
      check("abort_en x", x_out[0], 0);
      check("abort_en y", y_out[0], 0);
      check("abort_en active", rot_active[0], 0);
      check("abort_en ready", in_ready[0], 0);
      @(negedge clk);
      check("abort_en ignored_input", rot_active[0], 0);
      in_valid[0] = 1'b0;
      enable = 1'b1;
      @(negedge clk);
      run_op(0, -1234, 4321, 16'b10, 0);

      // Abort with reset during ROT on the long instance.
      run_op(1, 1000, 0, 16'h0000, 0);
      x_in[1] = 22'sd5000; y_in[1] = -22'sd300; dir[1] = 16'h5a5a; in_valid[1] = 1'b1;
      @(posedge clk);
      #1 in_valid[1] = 1'b0;
      repeat (4) @(negedge clk);
      check("abort_rst rot_active_pre", rot_active[1], 1);
      reset = 1'b1;
      #1;
      check("abort_rst ready_in_reset", in_ready[1], 0);
      @(negedge clk);
      check("abort_rst valid", out_valid[1], 0);
      check("abort_rst x", x_out[1], 0);
      check("abort_rst y", y_out[1], 0);
      check("abort_rst active", rot_active[1], 0);
      reset = 1'b0;
      @(negedge clk);
      run_op(1, 31415, -27182, 16'h3c3c, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
